wb_reg_responder: RTL

Wishbone classic responder (slave) that terminates one window of the shared Wishbone address map. It implements a fixed 32-bit register layout: ID, sticky write-1-to-clear status, self-clearing pulse controls, read/write control registers and read-only fabric inputs. It sits behind the Wishbone interconnect at the slot selected from the base-address package, normally the user-design window (base 32'h80005200, 512 bytes). It returns single-cycle ack for mapped addresses and err for any access outside its window.

---
 rtl/wb_reg_responder_pkg.sv | 30 +++
 rtl/wb_sticky_w1c.sv | 23 ++
 rtl/wb_reg_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wb_reg_responder_pkg.sv
// Shared register offsets, termination states and decode helpers for the
// Wishbone register responder.
package wb_reg_responder_pkg;

  localparam logic [31:0] OFF_ID      = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0010;
  localparam logic [31:0] OFF_PULSE   = 32'h0000_0014;
  localparam logic [31:0] OFF_RW_BASE = 32'h0000_0040;
  localparam logic [31:0] OFF_RO_BASE = 32'h0000_0080;

  typedef enum logic {
    ST_IDLE,
    ST_TERM
  } term_state_t;

  // Word-aligned and inside [base, base+size); written as a difference so a
  // window ending at 2^32 does not overflow.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [31:0] off;
    off = adr - base;
    return (adr >= base) && (off < size) && (adr[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_sticky_w1c.sv
// 32-bit sticky status register: set pulses accumulate, write-1 clears,
// set beats clear on the same bit in the same cycle.
module wb_sticky_w1c (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_set,
  input  logic [31:0] i_clr,
  output logic [31:0] o_status
);

  logic [31:0] r_status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~i_clr) | i_set;
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/wb_reg_responder.sv
// Wishbone classic responder for one address window: ID, sticky status,
// pulse controls, R/W control registers and read-only fabric inputs.
module wb_reg_responder
  import wb_reg_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_5200,
  parameter int unsigned MEMORY_SIZE  = 512,
  parameter int unsigned NUM_RW       = 8,
  parameter int unsigned NUM_RO       = 4,
  parameter logic [31:0] ID_VALUE     = 32'h5349_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [31:0]            wb_adr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [NUM_RW*32-1:0]   rw_regs_o,
  input  logic [NUM_RO*32-1:0]   ro_regs_i,
  input  logic [31:0]            status_set_i,
  output logic [31:0]            pulse_o
);

  term_state_t r_state;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;
  logic [31:0] r_pulse;
  logic [31:0] r_rw [NUM_RW];

  logic        w_accept;
  logic        w_in_win;
  logic        w_wr;
  logic [31:0] w_off;
  logic [3:0]  w_idx;
  logic [31:0] w_wmask;
  logic [31:0] w_rdata;
  logic [31:0] w_clr;
  logic [31:0] w_status;

  assign w_accept = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_in_win = in_window(wb_adr_i, BASE_ADDRESS, 32'(MEMORY_SIZE));
  assign w_wr     = w_accept & w_in_win & wb_we_i;
  assign w_off    = wb_adr_i - BASE_ADDRESS;
  assign w_idx    = w_off[5:2];
  assign w_wmask  = sel_mask(wb_sel_i);
  assign w_clr    = (w_wr && (w_off == OFF_STATUS)) ? (wb_dat_i & w_wmask) : '0;

  // Unlisted offsets and indices beyond NUM_RW/NUM_RO fall through to zero.
  always_comb begin
    w_rdata = '0;
    if (w_off == OFF_ID) begin
      w_rdata = ID_VALUE;
    end else if (w_off == OFF_STATUS) begin
      w_rdata = w_status;
    end else if (w_off[31:6] == OFF_RW_BASE[31:6]) begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        if (w_idx == i[3:0]) w_rdata = r_rw[i];
      end
    end else if (w_off[31:6] == OFF_RO_BASE[31:6]) begin
      for (int unsigned i = 0; i < NUM_RO; i++) begin
        if (w_idx == i[3:0]) w_rdata = ro_regs_i[32*i +: 32];
      end
    end
  end

  wb_sticky_w1c u_status (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (status_set_i),
    .i_clr    (w_clr),
    .o_status (w_status)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_pulse <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) r_rw[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_dat   <= '0;
          r_pulse <= '0;
          if (w_accept) begin
            r_state <= ST_TERM;
            if (w_in_win) begin
              r_ack <= 1'b1;
              r_dat <= w_rdata;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (w_wr) begin
            if (w_off == OFF_PULSE) r_pulse <= wb_dat_i & w_wmask;
            for (int unsigned i = 0; i < NUM_RW; i++) begin
              if (w_off == OFF_RW_BASE + 32'(4 * i))
                r_rw[i] <= (r_rw[i] & ~w_wmask) | (wb_dat_i & w_wmask);
            end
          end
        end
        ST_TERM: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_dat   <= '0;
          r_pulse <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rw_regs_o = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) rw_regs_o[32*i +: 32] = r_rw[i];
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;
  assign pulse_o  = r_pulse;

endmodule
